synthesizer_soc_sample_fifo: RTL and testbench
==============================================

Name: synthesizer_soc_sample_fifo

Overview:
Avalon-MM slave sample buffer that sits directly downstream of the periodic timer's interrupt. On each timer irq the CPU pushes a batch of synthesized audio samples into this FIFO. A free-running sample-rate strobe then drains the FIFO one sample per tick towards the DAC/I2S serializer. A level-sensitive low-watermark irq tells the CPU when to refill.

Parameters:
DATA_WIDTH, 16, width of one audio sample and of writedata/readdata
DEPTH, 16, FIFO entries; must be a power of two, 4..256
CNT_W, 5, count width = log2(DEPTH)+1

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
address  input  2  register select, 0..3
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  DATA_WIDTH  write data
readdata  output  DATA_WIDTH  registered read data
sample_tick  input  1  one-cycle pulse at the audio sample rate
sample_out  output  DATA_WIDTH  current sample to the DAC, held between ticks
sample_valid  output  1  one-cycle pulse when sample_out has been updated
irq  output  1  low-watermark interrupt, level

Behaviour:
- Reset (async, reset_n=0): rd/wr pointers 0; count 0; sample_out 0; sample_valid 0; readdata 0; control 0 (irq disabled, drain disabled); watermark DEPTH/2; sticky flags 0; irq 0.
- Write strobe: chipselect && ~write_n. Read mux is registered, so readdata is valid 1 cycle after address is presented, regardless of chipselect.
- Register map:
  - addr0 DATA: a write pushes writedata; a read returns 0.
  - addr1 STATUS: read gives bit0 empty, bit1 full, bit2 underflow (sticky), bit3 overflow (sticky), bits[8+CNT_W-1:8] count. A write clears bit2 and/or bit3 where the corresponding writedata bit is 1 (write-1-to-clear).
  - addr2 CONTROL: bits[1:0] read/write; bit0 irq_enable, bit1 drain_enable.
  - addr3 WATERMARK: bits[CNT_W-1:0] read/write.
- Push: if count==DEPTH before the edge, the data is dropped, overflow sets, and pointers/count are unchanged, even if a pop occurs in the same cycle. Otherwise mem[wr_ptr]<=writedata, and wr_ptr wraps modulo DEPTH.
- Pop, on sample_tick && drain_enable:
  - If count>0: sample_out<=mem[rd_ptr], rd_ptr wraps modulo DEPTH.
  - If count==0: sample_out holds its previous value and underflow sets.
  - In both cases sample_valid=1 in the cycle after the tick.
- With drain_enable=0, ticks are ignored: no pop, no sample_valid, no underflow.
- Simultaneous push and pop (not full): count unchanged, both pointers advance. A push into an empty FIFO in the same cycle as a tick is an underflow; the pushed word stays in the FIFO.
- Simultaneous sticky-flag set and W1C clear in the same cycle: the set wins.
- count is always in 0..DEPTH; empty = (count==0); full = (count==DEPTH).
- irq = irq_enable && (count <= watermark), registered (1 cycle after count changes). A watermark >= DEPTH keeps irq asserted whenever irq_enable=1.
- Reset mid-operation discards all FIFO content immediately. Memory contents need not be cleared.

Test Plan:
1. Reset, then read addr1 -> readdata 0x0001 (empty) one cycle later; read addr3 -> 0x0008; irq=0, sample_out=0.
2. Push 0x1111,0x2222,0x3333; set CONTROL=0x2; issue 3 ticks -> sample_out 0x1111,0x2222,0x3333 each with a 1-cycle sample_valid pulse; STATUS count=0, empty=1.
3. Push 17 words into DEPTH=16 -> full=1, overflow=1, count=16. Drain 16 ticks -> first 16 values in order; the 17th is lost. Write STATUS 0x0008 -> overflow clears.
4. Empty FIFO, drain enabled, tick -> sample_out holds last value, sample_valid pulses, underflow=1. Same-cycle push+tick on empty -> underflow=1, count=1 afterwards.
5. CONTROL=0x3, WATERMARK=4, push 6 -> irq=0. Drain 2 -> irq rises 1 cycle after count reaches 4. Push 1 -> irq falls. Clear CONTROL bit0 -> irq=0 immediately on the next cycle.
6. Full FIFO plus push and tick in the same cycle -> push dropped (overflow=1), pop succeeds, count=15; assert reset_n mid-drain -> count=0, sample_valid=0, control=0.

Source files
------------

// File: rtl/synthesizer_soc_sample_fifo.sv
// -----------------------------------------------------------------------------
// synthesizer_soc_sample_fifo
// Avalon-MM slave audio sample buffer. The CPU pushes synthesized samples
// through the DATA register, and a sample-rate strobe drains one sample per tick
// towards the DAC. A level-sensitive low-watermark interrupt requests a refill.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   address      register select (0 DATA, 1 STATUS, 2 CONTROL, 3 WATERMARK)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data
//   readdata     registered read data, valid one cycle after address
//   sample_tick  one-cycle pulse at the audio sample rate
//   sample_out   current sample to the DAC, held between ticks
//   sample_valid one-cycle pulse after each enabled tick
//   irq          low-watermark interrupt (level, registered)
// -----------------------------------------------------------------------------
module synthesizer_soc_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  input  logic                  sample_tick,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  irq
);

  localparam int               AW      = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WM_RST  = CNT_W'(DEPTH / 2);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [CNT_W-1:0]      wm_q, wm_d;
  logic                  unf_q, unf_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_q, irq_d;

  logic                  wr_s, push_s, pop_req_s, push_ok_s, pop_ok_s;
  logic                  empty_s, full_s;
  logic [DATA_WIDTH-1:0] status_s;

  assign empty_s   = (count_q == {CNT_W{1'b0}});
  assign full_s    = (count_q == DEPTH_C);
  assign wr_s      = chipselect && !write_n;
  assign push_s    = wr_s && (address == 2'd0);
  assign pop_req_s = sample_tick && ctrl_q[1];
  // Full/empty are judged on the state before the edge, so a same-cycle pop
  // never makes room for a push and a same-cycle push never feeds a pop.
  assign push_ok_s = push_s && !full_s;
  assign pop_ok_s  = pop_req_s && !empty_s;

  // Status word assembly
  always_comb begin
    status_s            = {DATA_WIDTH{1'b0}};
    status_s[0]         = empty_s;
    status_s[1]         = full_s;
    status_s[2]         = unf_q;
    status_s[3]         = ovf_q;
    status_s[8 +: CNT_W] = count_q;
  end

  // Next-state logic for pointers, count, flags, registers and outputs
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sample_d = sample_q;
    ctrl_d   = ctrl_q;
    wm_d     = wm_q;
    unf_d    = unf_q;
    ovf_d    = ovf_q;
    rdata_d  = {DATA_WIDTH{1'b0}};

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      sample_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // W1C clear first, then set, so a same-cycle event wins over the clear.
    if (wr_s && (address == 2'd1)) begin
      unf_d = unf_q & ~writedata[2];
      ovf_d = ovf_q & ~writedata[3];
    end else begin
      unf_d = unf_q;
      ovf_d = ovf_q;
    end
    if (pop_req_s && empty_s) begin
      unf_d = 1'b1;
    end else begin
      unf_d = unf_d;
    end
    if (push_s && full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end

    if (wr_s && (address == 2'd2)) begin
      ctrl_d = writedata[1:0];
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_s && (address == 2'd3)) begin
      wm_d = writedata[CNT_W-1:0];
    end else begin
      wm_d = wm_q;
    end

    // Read mux is registered independently of chipselect.
    case (address)
      2'd0:    rdata_d = {DATA_WIDTH{1'b0}};
      2'd1:    rdata_d = status_s;
      2'd2:    rdata_d = {{(DATA_WIDTH-2){1'b0}}, ctrl_q};
      2'd3:    rdata_d = {{(DATA_WIDTH-CNT_W){1'b0}}, wm_q};
      default: rdata_d = {DATA_WIDTH{1'b0}};
    endcase

    valid_d = pop_req_s;
    // Uses the current count, so irq trails a count change by one cycle.
    irq_d   = ctrl_q[0] && (count_q <= wm_q);
  end

  // Sample storage; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= writedata;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      sample_q <= {DATA_WIDTH{1'b0}};
      valid_q  <= 1'b0;
      rdata_q  <= {DATA_WIDTH{1'b0}};
      ctrl_q   <= 2'b00;
      wm_q     <= WM_RST;
      unf_q    <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      ctrl_q   <= ctrl_d;
      wm_q     <= wm_d;
      unf_q    <= unf_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign readdata     = rdata_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_synthesizer_soc_sample_fifo.sv
module tb_synthesizer_soc_sample_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        sample_tick = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [15:0] rd;

  synthesizer_soc_sample_fifo #(.DATA_WIDTH(16), .DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .sample_tick(sample_tick), .sample_out(sample_out),
    .sample_valid(sample_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  // one tick; returns at the negedge after the tick edge
  task automatic tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (readdata !== 16'h0000) begin failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 16'h0000); end
    reset_n = 1'b1;
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL reset_status got=%h exp=%h", rd, 16'h0001); end
    bus_read(2'd3, rd);
    checks++; if (rd !== 16'h0008) begin failures++; $display("FAIL reset_wm got=%h exp=%h", rd, 16'h0008); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (sample_out !== 16'h0000) begin failures++; $display("FAIL reset_sample got=%h exp=0000", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
  endtask

  task automatic test_basic_drain();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'h1111; exp_v[1] = 16'h2222; exp_v[2] = 16'h3333;
    for (int i = 0; i < 3; i++) bus_write(2'd0, exp_v[i]);
    bus_read(2'd0, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL data_read got=%h exp=0000", rd); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0300) begin failures++; $display("FAIL basic_count3 got=%h exp=0300", rd); end
    bus_write(2'd2, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (sample_out !== exp_v[i] || sample_valid !== 1'b1) begin
        failures++; $display("FAIL basic_tick%0d got=%h/%b exp=%h/1", i, sample_out, sample_valid, exp_v[i]);
      end
      @(negedge clk);
      checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse%0d got=%b exp=0", i, sample_valid); end
    end
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL basic_empty got=%h exp=0001", rd); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) bus_write(2'd0, 16'h0A00 + 16'(i));
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h100A) begin failures++; $display("FAIL ovf_status got=%h exp=100a", rd); end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (sample_out !== 16'h0A00 + 16'(i)) begin
        failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, sample_out, 16'h0A00 + 16'(i));
      end
    end
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0009) begin failures++; $display("FAIL ovf_after_drain got=%h exp=0009", rd); end
    bus_write(2'd1, 16'h0008);
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL ovf_w1c got=%h exp=0001", rd); end
  endtask

  task automatic test_underflow();
    tick();
    checks++; if (sample_out !== 16'h0A0F || sample_valid !== 1'b1) begin
      failures++; $display("FAIL unf_hold got=%h/%b exp=0a0f/1", sample_out, sample_valid);
    end
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0005) begin failures++; $display("FAIL unf_status got=%h exp=0005", rd); end
    bus_write(2'd1, 16'h0004);
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL unf_w1c got=%h exp=0001", rd); end
    // push and tick together on an empty FIFO
    @(negedge clk);
    address = 2'd0; writedata = 16'hBEEF; chipselect = 1'b1; write_n = 1'b0; sample_tick = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; sample_tick = 1'b0;
    checks++; if (sample_out !== 16'h0A0F || sample_valid !== 1'b1) begin
      failures++; $display("FAIL unf_same_cycle got=%h/%b exp=0a0f/1", sample_out, sample_valid);
    end
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0104) begin failures++; $display("FAIL unf_same_status got=%h exp=0104", rd); end
    tick();
    checks++; if (sample_out !== 16'hBEEF) begin failures++; $display("FAIL unf_kept_word got=%h exp=beef", sample_out); end
    bus_write(2'd1, 16'h0004);
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL unf_final got=%h exp=0001", rd); end
  endtask

  task automatic test_irq();
    bus_write(2'd2, 16'h0003);
    bus_write(2'd3, 16'h0004);
    bus_read(2'd3, rd);
    checks++; if (rd !== 16'h0004) begin failures++; $display("FAIL irq_wm_read got=%h exp=0004", rd); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_empty got=%b exp=1", irq); end
    for (int i = 0; i < 6; i++) bus_write(2'd0, 16'h5000 + 16'(i));
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_above_wm got=%b exp=0", irq); end
    tick();
    checks++; if (sample_out !== 16'h5000) begin failures++; $display("FAIL irq_pop0 got=%h exp=5000", sample_out); end
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_latency got=%b exp=0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
    bus_write(2'd0, 16'h5006);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq); end
    tick();
    checks++; if (sample_out !== 16'h5002) begin failures++; $display("FAIL irq_pop2 got=%h exp=5002", sample_out); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise2 got=%b exp=1", irq); end
    bus_write(2'd2, 16'h0002);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_disable got=%b exp=0", irq); end
    bus_read(2'd2, rd);
    checks++; if (rd !== 16'h0002) begin failures++; $display("FAIL irq_ctrl_read got=%h exp=0002", rd); end
  endtask

  task automatic test_full_push_pop_and_reset();
    // 4 entries remain (5003..5006); fill to 16
    for (int i = 0; i < 12; i++) bus_write(2'd0, 16'h6000 + 16'(i));
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h1002) begin failures++; $display("FAIL full_status got=%h exp=1002", rd); end
    @(negedge clk);
    address = 2'd0; writedata = 16'hDEAD; chipselect = 1'b1; write_n = 1'b0; sample_tick = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; sample_tick = 1'b0;
    checks++; if (sample_out !== 16'h5003 || sample_valid !== 1'b1) begin
      failures++; $display("FAIL full_pop got=%h/%b exp=5003/1", sample_out, sample_valid);
    end
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0F08) begin failures++; $display("FAIL full_push_drop got=%h exp=0f08", rd); end
    tick();
    checks++; if (sample_out !== 16'h5004) begin failures++; $display("FAIL full_next got=%h exp=5004", sample_out); end
    // reset mid-drain
    @(negedge clk);
    sample_tick = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++; if (sample_valid !== 1'b0 || sample_out !== 16'h0000 || irq !== 1'b0) begin
      failures++; $display("FAIL rst_mid got=%b/%h/%b exp=0/0000/0", sample_valid, sample_out, irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL rst_tick_ignored got=%b exp=0", sample_valid); end
    sample_tick = 1'b0;
    bus_read(2'd1, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL rst_status got=%h exp=0001", rd); end
    bus_read(2'd2, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL rst_ctrl got=%h exp=0000", rd); end
    bus_read(2'd3, rd);
    checks++; if (rd !== 16'h0008) begin failures++; $display("FAIL rst_wm got=%h exp=0008", rd); end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_overflow();
    test_underflow();
    test_irq();
    test_full_push_pop_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
